// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_ctrl_pkg
// Description : Shared types and constants for the strobe-driven RAM
//               controller. Holds the controller state encoding, the default
//               RAM geometry and the helper that sizes the phase timer.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

    localparam int c_def_addr_w = 8;
    localparam int c_def_data_w = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    // The timer holds (phase length - 1) for the longer of the two timed
    // phases; one spare bit keeps the width >= 1 when both phases are 1 cycle.
    function automatic int timer_width(input int setup_cyc, input int strobe_cyc);
        int longest;
        longest = (setup_cyc > strobe_cyc) ? setup_cyc : strobe_cyc;
        return $clog2(longest) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_ctrl_strobe_timer.sv
`default_nettype none
// ============================================================================
// Module      : ram_strobe_timer
// Description : Load/decrement phase counter. Loaded with (cycles - 1) on
//               phase entry, counts down to zero and then idles there.
//               done is high while the count is zero, i.e. during the last
//               cycle of the current phase.
// Ports       : clk, rst_n     - clock, async active-low reset
//               load           - load load_val this cycle (has priority)
//               load_val       - reload value
//               done           - count has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module ram_strobe_timer
    import ram_ctrl_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_ctrl
// Description : Single-transaction initiator for a strobe-driven RAM macro.
//               Accepts one read/write request, sequences
//               SETUP -> STROBE -> HOLD around the RAM strobes, then presents
//               the response until it is consumed. Every output is a flop.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               req_valid/req_ready        - request handshake
//               req_we/req_addr/req_wdata  - request payload
//               rsp_valid/rsp_ready        - response handshake
//               rsp_we/rsp_rdata           - response payload (rdata 0 on writes)
//               mem_cs/mem_we/mem_re       - RAM chip select and strobes
//               mem_addr/mem_data          - RAM address / write data
//               mem_q                      - RAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = c_def_addr_w,
    parameter int DATA_W     = c_def_data_w,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int                 c_cnt_w       = timer_width(SETUP_CYC, STROBE_CYC);
    localparam logic [c_cnt_w-1:0] c_setup_load  = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_strobe_load = c_cnt_w'(STROBE_CYC - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_we;
    logic               w_timer_load;
    logic [c_cnt_w-1:0] w_timer_val;
    logic               w_timer_done;

    ram_strobe_timer #(
        .CNT_W (c_cnt_w)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_timer_load),
        .load_val (w_timer_val),
        .done     (w_timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The timer is reloaded on the edge that enters each timed phase, so it
    // reads (cycles - 1) in the phase's first cycle and done marks its last.
    always_comb begin
        w_next_state = r_state;
        w_timer_load = 1'b0;
        w_timer_val  = c_setup_load;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = SETUP;
                    w_timer_load = 1'b1;
                    w_timer_val  = c_setup_load;
                end
            end
            SETUP: begin
                if (w_timer_done) begin
                    w_next_state = STROBE;
                    w_timer_load = 1'b1;
                    w_timer_val  = c_strobe_load;
                end
            end
            STROBE: begin
                if (w_timer_done) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each output
    // changes on the same edge as the state it belongs to and no input reaches
    // an output without passing through a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            r_we      <= 1'b0;
        end else begin
            req_ready <= (w_next_state == IDLE);
            rsp_valid <= (w_next_state == RESP);
            mem_cs    <= (w_next_state == SETUP) || (w_next_state == STROBE) ||
                         (w_next_state == HOLD);
            // r_we was latched when SETUP was entered, well before STROBE.
            mem_we    <= (w_next_state == STROBE) && r_we;
            mem_re    <= (w_next_state == STROBE) && !r_we;

            // The mem_addr/mem_data flops double as the request latch; they
            // are only written on acceptance, so they stay put through RESP.
            if ((r_state == IDLE) && req_valid) begin
                r_we     <= req_we;
                mem_addr <= req_addr;
                mem_data <= req_we ? req_wdata : '0;
            end

            // mem_q was refreshed by the mem_re rising edge during STROBE and
            // is sampled on the edge leaving HOLD.
            if (r_state == HOLD) begin
                rsp_we    <= r_we;
                rsp_rdata <= r_we ? '0 : mem_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_ctrl
// Description : Scoreboard bench for ram_ctrl. Two instances: index 0 uses
//               the default 1/1 timing, index 1 uses SETUP_CYC=3,
//               STROBE_CYC=2. A behavioural RAM model sits on each memory
//               port; a per-instance monitor checks phase timing every cycle
//               and pops expected responses from a shared queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_ctrl;

    typedef struct packed {
        logic        we;
        logic [15:0] rdata;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [7:0]  req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic        rsp_we    [2];
    logic [15:0] rsp_rdata [2];
    logic        mem_cs    [2];
    logic        mem_we    [2];
    logic        mem_re    [2];
    logic [7:0]  mem_addr  [2];
    logic [15:0] mem_data  [2];
    logic [15:0] mem_q     [2];

    logic [15:0] ram     [2][256];
    logic [15:0] ref_mem [2][256];
    rsp_t        exp_q[$];

    int          errors = 0;
    int          checks = 0;
    bit          busy   [2];
    int          k_cnt  [2];
    logic        e_we   [2];
    logic [7:0]  e_addr [2];
    logic [15:0] e_data [2];
    int          rr_mode;
    logic        rr_manual;
    bit          ok;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int c_s = (gi == 0) ? 1 : 3;
        localparam int c_p = (gi == 0) ? 1 : 2;

        ram_ctrl #(
            .ADDR_W     (8),
            .DATA_W     (16),
            .SETUP_CYC  (c_s),
            .STROBE_CYC (c_p)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_we    (req_we[gi]),
            .req_addr  (req_addr[gi]),
            .req_wdata (req_wdata[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_ready (rsp_ready[gi]),
            .rsp_we    (rsp_we[gi]),
            .rsp_rdata (rsp_rdata[gi]),
            .mem_cs    (mem_cs[gi]),
            .mem_we    (mem_we[gi]),
            .mem_re    (mem_re[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_data  (mem_data[gi]),
            .mem_q     (mem_q[gi])
        );

        // RAM macro: writes on the rising write strobe, updates q on the
        // rising read strobe.
        always @(posedge mem_we[gi]) ram[gi][mem_addr[gi]] <= mem_data[gi];
        always @(posedge mem_re[gi]) mem_q[gi] <= ram[gi][mem_addr[gi]];

        // k counts cycles after the accepting edge: 1..S setup, S+1..S+P
        // strobe, S+P+1 hold, S+P+2 onward response.
        always @(negedge clk) begin : p_mon
            logic in_cs, in_stb, in_rsp;
            rsp_t e;
            if (!rst_n) begin
                chk("reset_req_ready", gi, 32'(req_ready[gi]), 32'd1);
                chk("reset_ctrl_outs", gi, 32'({mem_cs[gi], mem_we[gi], mem_re[gi],
                                                rsp_valid[gi], rsp_we[gi]}), 32'd0);
                chk("reset_addr_data", gi, {8'h00, mem_addr[gi], mem_data[gi]}, 32'd0);
                chk("reset_rdata", gi, 32'(rsp_rdata[gi]), 32'd0);
                busy[gi] = 1'b0;
                exp_q.delete();
            end else if (!busy[gi]) begin
                chk("idle_req_ready", gi, 32'(req_ready[gi]), 32'd1);
                chk("idle_quiet", gi, 32'({mem_cs[gi], mem_we[gi], mem_re[gi],
                                           rsp_valid[gi]}), 32'd0);
                if (req_valid[gi]) begin
                    busy[gi]   = 1'b1;
                    k_cnt[gi]  = 0;
                    e_we[gi]   = req_we[gi];
                    e_addr[gi] = req_addr[gi];
                    e_data[gi] = req_we[gi] ? req_wdata[gi] : 16'h0000;
                    e.we       = req_we[gi];
                    e.rdata    = req_we[gi] ? 16'h0000 : ref_mem[gi][req_addr[gi]];
                    if (req_we[gi]) ref_mem[gi][req_addr[gi]] = req_wdata[gi];
                    exp_q.push_back(e);
                end
            end else begin
                k_cnt[gi]++;
                in_cs  = (k_cnt[gi] >= 1) && (k_cnt[gi] <= c_s + c_p + 1);
                in_stb = (k_cnt[gi] >= c_s + 1) && (k_cnt[gi] <= c_s + c_p);
                in_rsp = (k_cnt[gi] >= c_s + c_p + 2);
                chk("busy_req_ready", gi, 32'(req_ready[gi]), 32'd0);
                chk("mem_cs", gi, 32'(mem_cs[gi]), 32'(in_cs));
                chk("mem_we", gi, 32'(mem_we[gi]), 32'(in_stb && e_we[gi]));
                chk("mem_re", gi, 32'(mem_re[gi]), 32'(in_stb && !e_we[gi]));
                chk("mem_addr_data", gi, {8'h00, mem_addr[gi], mem_data[gi]},
                    {8'h00, e_addr[gi], e_data[gi]});
                chk("rsp_valid", gi, 32'(rsp_valid[gi]), 32'(in_rsp));
                if (in_rsp) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected dut%0d: got a response, expected none", gi);
                    end else begin
                        chk("rsp_we", gi, 32'(rsp_we[gi]), 32'(exp_q[0].we));
                        chk("rsp_rdata", gi, 32'(rsp_rdata[gi]), 32'(exp_q[0].rdata));
                        if (rsp_ready[gi]) begin
                            void'(exp_q.pop_front());
                            busy[gi] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Sole driver of rsp_ready: always ready, random, or a manual level.
    initial begin
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (rr_mode == 0)      rsp_ready[d] = 1'b1;
                else if (rr_mode == 1) rsp_ready[d] = 1'($urandom_range(0, 1));
                else                   rsp_ready[d] = rr_manual;
            end
        end
    end

    task automatic issue(input int d, input logic we, input logic [7:0] a,
                         input logic [15:0] wd);
        bit acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: req_ready stayed 0, expected 1", d);
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if (!busy[d]) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout dut%0d: still busy, expected idle", d);
        end
    endtask

    // Junk request held for one cycle while the controller is busy.
    task automatic pulse_extra(input int d);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b1;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = 8'($urandom);
        req_wdata[d] = 16'($urandom);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic rand_phase(input int d, input int n);
        logic [7:0] wl[$];
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            if (wl.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = 8'($urandom_range(0, 15)) ^ (($urandom_range(0, 1) == 1) ? 8'hF0 : 8'h00);
                issue(d, 1'b1, a, 16'($urandom));
                wl.push_back(a);
            end else begin
                a = wl[$urandom_range(0, wl.size() - 1)];
                issue(d, 1'b0, a, 16'h0000);
            end
        end
        wait_idle(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rr_mode   = 0;
        rr_manual = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 8'h00;
            req_wdata[d] = 16'h0000;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single write then read-back of 0x12.
        issue(0, 1'b1, 8'h12, 16'hBEEF);
        wait_idle(0);
        chk("ram_model_0x12", 0, 32'(ram[0][8'h12]), 32'h0000BEEF);
        issue(0, 1'b0, 8'h12, 16'h0000);
        wait_idle(0);

        // Back-to-back transactions with junk requests while busy.
        issue(0, 1'b1, 8'h00, 16'h0001);
        pulse_extra(0);
        issue(0, 1'b1, 8'hFF, 16'hFFFF);
        pulse_extra(0);
        issue(0, 1'b0, 8'h00, 16'h0000);
        issue(0, 1'b0, 8'hFF, 16'h0000);
        wait_idle(0);

        // Response backpressure for 10 cycles.
        rr_mode   = 2;
        rr_manual = 1'b0;
        issue(0, 1'b0, 8'h12, 16'h0000);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout dut0: rsp_valid stayed 0, expected 1");
        end
        repeat (10) @(negedge clk);
        rr_manual = 1'b1;
        wait_idle(0);
        rr_mode = 0;

        // Randomized traffic with random response backpressure.
        rr_mode = 1;
        rand_phase(0, 40);
        rr_mode = 0;

        // Stretched timing instance.
        issue(1, 1'b1, 8'h55, 16'hA5A5);
        wait_idle(1);
        issue(1, 1'b0, 8'h55, 16'h0000);
        wait_idle(1);
        rr_mode = 1;
        rand_phase(1, 15);
        rr_mode = 0;

        // Reset while the write strobe is high.
        issue(0, 1'b1, 8'h40, 16'h1234);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (mem_we[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout dut0: mem_we stayed 0, expected 1");
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("async_rst_outs", 0, 32'({mem_cs[0], mem_we[0], mem_re[0], rsp_valid[0]}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(0, 1'b0, 8'h40, 16'h0000);
        wait_idle(0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Clocked initiator for the 256x16 strobe-driven data RAM.
- Accepts single-beat read/write requests from the MCU core over a valid/ready interface.
- Generates the RAM's mem_cs/mem_we/mem_re strobes with programmable setup and pulse widths, holds addr/data stable around each strobe edge, and returns read data over a valid/ready response channel.
- Sits between the core's load/store unit and the RAM macro.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- SETUP_CYC, 1, clock cycles mem_cs/addr/data are stable before the strobe rises (>=1).
- STROBE_CYC, 1, clock cycles mem_we/mem_re stays high (>=1).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  transaction complete; rsp_rdata valid for reads.
- rsp_ready  in  1  consumer accepts response.
- rsp_we  out  1  echo of the completed request's req_we.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write strobe; the RAM writes on the rising edge.
- mem_re  out  1  RAM read strobe; the RAM updates mem_q on the rising edge.
- mem_addr  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_q  in  DATA_W  RAM read data.

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - All outputs 0 except req_ready=1.
  - Address, data, rdata and we registers cleared.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_we/addr/wdata; next state SETUP; req_ready=0 next cycle.
- SETUP, SETUP_CYC cycles:
  - mem_cs=1, mem_addr/mem_data driven from latched values, mem_we=mem_re=0.
  - mem_data=0 for reads.
- STROBE, STROBE_CYC cycles:
  - mem_cs=1, addr/data unchanged.
  - mem_we=1 if write, else mem_re=1.
  - Exactly one of the two strobes is high.
- HOLD, 1 cycle:
  - Strobes 0; mem_cs, addr and data unchanged.
  - For reads, mem_q is captured into rsp_rdata on the clock edge leaving HOLD.
- RESP:
  - mem_cs=0, mem_addr/mem_data keep their last values.
  - rsp_valid=1 with rsp_we, rsp_rdata stable until rsp_ready.
  - rsp_valid && rsp_ready: rsp_valid=0 next cycle, state IDLE.
- Latency with defaults:
  - Accept at edge T.
  - mem_cs rises at T+1, strobe at T+2, HOLD at T+3, rsp_valid at T+4.
  - With rsp_ready=1, req_ready returns at T+5. Throughput is 1 transaction per 5 cycles.
  - General: rsp_valid at T+1+SETUP_CYC+STROBE_CYC+1.
- Backpressure: rsp_ready=0 holds RESP indefinitely. No new request is accepted, and no strobe is issued.
- Only one transaction is in flight. A req_valid seen outside IDLE is ignored.
- Addresses are used as given. There is no wrap or increment logic; all 2^ADDR_W addresses are legal.
- Reset mid-operation: outputs drop to reset values immediately and may truncate a strobe.
  - A write whose mem_we rising edge already occurred is committed.
  - No response is produced for the aborted transaction.
- Timer: one down-counter, loaded on entry to SETUP and STROBE, decremented each cycle. The state advances when the count reaches 0.
- Counter width is clog2(max(SETUP_CYC,STROBE_CYC))+1.

Decomposition:
- ram_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, RESP);
  - default ADDR_W/DATA_W constants;
  - a timer-width function.
- Optional sub-module ram_strobe_timer:
  - parameterised load/decrement counter with a done flag.
  - Remaining logic stays in ram_ctrl.

Test Plan:
- Single write, addr=0x12, wdata=0xBEEF, rsp_ready=1:
  - mem_cs high cycles T+1..T+3.
  - mem_we high only at T+2; mem_re never asserts.
  - rsp_valid at T+4 with rsp_we=1, rsp_rdata=0; RAM model holds 0xBEEF at 0x12.
- Read back 0x12:
  - mem_re pulses once; rsp_rdata=0xBEEF, rsp_we=0 at T+4.
  - addr stable from mem_cs rise through HOLD.
- Back-to-back writes 0x00=0x0001 and 0xFF=0xFFFF, then read both:
  - correct data returned; req_ready low during each transaction.
  - Extra req_valid pulses while busy are ignored.
- rsp_ready held 0 for 10 cycles after a read:
  - rsp_valid and rsp_rdata stable; no strobe activity.
  - rsp_ready=1 then returns IDLE the next cycle.
- SETUP_CYC=3, STROBE_CYC=2:
  - mem_cs-to-strobe gap is 3 cycles, strobe width is 2, rsp_valid at T+7.
- rst_n asserted while mem_we high at 0x40=0x1234:
  - all outputs reset asynchronously; no rsp_valid.
  - After release, req_ready=1 and a read of 0x40 returns 0x1234.
